// File: rtl/text_term_writer_pkg.sv
// Shared constants, control codes and FSM states for the text terminal writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_term_pkg;

  localparam int COLS   = 80;           // 640 px / 8 px glyph
  localparam int ROWS   = 30;           // 480 px / 16 px glyph
  localparam int CELLS  = COLS * ROWS;
  localparam int ADDR_W = 12;           // CELLS must fit in 2**ADDR_W

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LINECLR
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_term_writer_if.sv
// Byte-in / char-memory-write-out bundle of the text terminal writer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready; the source holds its byte while in_ready is low.
// master: the writer (consumes the byte stream, drives the memory port and cursor).
// slave : the byte source / memory side.
interface text_term_writer_if
  import text_term_pkg::*;
#(
  parameter int AW = ADDR_W
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic [6:0]    cursor_col;
  logic [4:0]    cursor_row;
  logic          busy;

  modport master (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_data, cursor_col, cursor_row, busy
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_data, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_term_writer_cursor.sv
// Text cursor: column, row and row_base (= row*COLS, kept incrementally, no multiplier).
// Latency: an operation strobed in a cycle is visible after the next rising edge.
// Backpressure: none; at most one operation is strobed per cycle by the caller.
// Ports: i_advance (col+1 with wrap), i_newline (col 0, next row), i_cr (col 0),
//        i_home (0/0), i_back (col-1 if col>0); o_col/o_row/o_row_base; o_col_zero,
//        and o_col_last (next advance moves to a new row) when TEXT_TERM_LINE_CLEAR_EN.
module text_cursor
  import text_term_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  input  logic              i_newline,
  input  logic              i_cr,
  input  logic              i_home,
  input  logic              i_back,
  output logic [6:0]        o_col,
  output logic [4:0]        o_row,
  output logic [ADDR_W-1:0] o_row_base,
  output logic              o_col_zero
`ifdef TEXT_TERM_LINE_CLEAR_EN
  ,
  output logic              o_col_last
`endif
);
  logic [6:0]        r_col;
  logic [4:0]        r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic              w_col_last;
  logic              w_row_last;

  assign w_col_last = (r_col == 7'(COLS - 1));
  assign w_row_last = (r_row == 5'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_home) begin
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
    end else if (i_newline || (i_advance && w_col_last)) begin
      r_col <= '0;
      // No scrolling: the bottom row wraps to the top.
      if (w_row_last) begin
        r_row      <= '0;
        r_row_base <= '0;
      end else begin
        r_row      <= r_row + 5'd1;
        r_row_base <= r_row_base + ADDR_W'(COLS);
      end
    end else if (i_advance) begin
      r_col <= r_col + 7'd1;
    end else if (i_cr) begin
      r_col <= '0;
    end else if (i_back && (r_col != 7'd0)) begin
      r_col <= r_col - 7'd1;
    end
  end

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_row_base = r_row_base;
  assign o_col_zero = (r_col == 7'd0);
`ifdef TEXT_TERM_LINE_CLEAR_EN
  assign o_col_last = w_col_last;
`endif
endmodule

// File: rtl/text_term_writer.sv
// Byte stream -> 80x30 character memory writer with cursor, control codes and screen clear.
// Latency: byte accepted at edge N -> mem_we/addr/data and cursor valid from edge N (1 cycle).
// Backpressure: in_ready = IDLE; low during full clear sweep (and line clear when enabled).
// Ports: clk, rst_n (async active-low); bus (master): in_valid/in_data/in_ready,
//        mem_we/mem_addr/mem_data, cursor_col/cursor_row, busy.
// Optional: TEXT_TERM_LINE_CLEAR_EN blanks each row as the cursor moves onto it.
module text_term_writer
  import text_term_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  text_term_writer_if.master bus
);
  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_idx, w_idx_nx;
  logic              r_we, w_we_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [7:0]        r_data, w_data_nx;

  logic              w_adv, w_nl, w_cr, w_home, w_back;
  logic [6:0]        w_col;
  logic [4:0]        w_row;
  logic [ADDR_W-1:0] w_row_base;
  logic [ADDR_W-1:0] w_cell;
  logic              w_col_zero;
`ifdef TEXT_TERM_LINE_CLEAR_EN
  logic              w_col_last;
`endif

  text_cursor u_cursor (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_advance  (w_adv),
    .i_newline  (w_nl),
    .i_cr       (w_cr),
    .i_home     (w_home),
    .i_back     (w_back),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_row_base (w_row_base),
    .o_col_zero (w_col_zero)
`ifdef TEXT_TERM_LINE_CLEAR_EN
    ,
    .o_col_last (w_col_last)
`endif
  );

  assign w_cell = w_row_base + ADDR_W'(w_col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= CH_SPACE;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_we_nx    = 1'b0;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_adv      = 1'b0;
    w_nl       = 1'b0;
    w_cr       = 1'b0;
    w_home     = 1'b0;
    w_back     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (is_printable(bus.in_data)) begin
            w_we_nx   = 1'b1;
            w_addr_nx = w_cell;
            w_data_nx = bus.in_data;
            w_adv     = 1'b1;
`ifdef TEXT_TERM_LINE_CLEAR_EN
            // Auto-wrap: this write goes out now, the new row is blanked next.
            if (w_col_last) begin
              w_state_nx = ST_LINECLR;
              w_idx_nx   = '0;
            end
`endif
          end else begin
            case (bus.in_data)
              CH_LF: begin
                w_nl = 1'b1;
`ifdef TEXT_TERM_LINE_CLEAR_EN
                w_state_nx = ST_LINECLR;
                w_idx_nx   = '0;
`endif
              end
              CH_CR: w_cr = 1'b1;
              CH_BS: begin
                // Column 0 is a no-op: backspace never climbs to the previous row.
                if (!w_col_zero) begin
                  w_back    = 1'b1;
                  w_we_nx   = 1'b1;
                  w_addr_nx = w_cell - ADDR_W'(1);
                  w_data_nx = CH_SPACE;
                end
              end
              CH_FF: begin
                w_home     = 1'b1;
                w_state_nx = ST_CLEAR;
                w_idx_nx   = '0;
              end
              default: ; // other codes are swallowed
            endcase
          end
        end
      end
      ST_CLEAR: begin
        w_we_nx   = 1'b1;
        w_addr_nx = r_idx;
        w_data_nx = CH_SPACE;
        if (r_idx == ADDR_W'(CELLS - 1)) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
        end else begin
          w_idx_nx = r_idx + ADDR_W'(1);
        end
      end
`ifdef TEXT_TERM_LINE_CLEAR_EN
      ST_LINECLR: begin
        // Cursor already sits on the new row, so row_base points at it.
        w_we_nx   = 1'b1;
        w_addr_nx = w_row_base + r_idx;
        w_data_nx = CH_SPACE;
        if (r_idx == ADDR_W'(COLS - 1)) begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
        end else begin
          w_idx_nx = r_idx + ADDR_W'(1);
        end
      end
`endif
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.busy       = (r_state == ST_CLEAR);
  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_data   = r_data;
  assign bus.cursor_col = w_col;
  assign bus.cursor_row = w_row;
endmodule

// File: tb/tb_text_term_writer.sv
module tb_text_term_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  text_term_writer_if #(.AW(12)) bus ();

  text_term_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // Offer one byte; returns #1 after the accepting edge with in_valid dropped.
  task automatic send(input logic [7:0] b);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  // Expect a full sweep: 2400 writes of 0x20 at addresses 0..2399, then IDLE at 0/0.
  task automatic check_sweep(input string tag);
    int cnt = 0;
    int errs = 0;
    bit done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        if (bus.mem_addr !== 12'(cnt) || bus.mem_data !== 8'h20) errs++;
        cnt++;
      end else if (bus.in_ready) begin
        done = 1'b1;
      end
    end
    check({tag, "_count"}, cnt, 32'd2400);
    check({tag, "_cells"}, errs, 32'd0);
    check({tag, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_col"}, {25'd0, bus.cursor_col}, 32'd0);
    check({tag, "_row"}, {27'd0, bus.cursor_row}, 32'd0);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_we",    {31'd0, bus.mem_we},   32'd0);
    check("rst_addr",  {20'd0, bus.mem_addr}, 32'd0);
    check("rst_data",  {24'd0, bus.mem_data}, 32'h20);
    check("rst_busy",  {31'd0, bus.busy},     32'd1);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_sweep("boot");

    // "AB" back to back
    wait_ready();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    @(posedge clk);
    #1;
    check("a_we",   {31'd0, bus.mem_we},   32'd1);
    check("a_addr", {20'd0, bus.mem_addr}, 32'd0);
    check("a_data", {24'd0, bus.mem_data}, 32'h41);
    bus.in_data = 8'h42;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("b_we",   {31'd0, bus.mem_we},     32'd1);
    check("b_addr", {20'd0, bus.mem_addr},   32'd1);
    check("b_data", {24'd0, bus.mem_data},   32'h42);
    check("b_col",  {25'd0, bus.cursor_col}, 32'd2);

    // Unlisted control code is swallowed
    send(8'h07);
    check("bel_we",  {31'd0, bus.mem_we},     32'd0);
    check("bel_col", {25'd0, bus.cursor_col}, 32'd2);

    // Auto-wrap from column 79
    send_n(8'h78, 77);
    check("c79_col", {25'd0, bus.cursor_col}, 32'd79);
    send(8'h5A);
    check("wrap_we",   {31'd0, bus.mem_we},     32'd1);
    check("wrap_addr", {20'd0, bus.mem_addr},   32'd79);
    check("wrap_data", {24'd0, bus.mem_data},   32'h5A);
    check("wrap_col",  {25'd0, bus.cursor_col}, 32'd0);
    check("wrap_row",  {27'd0, bus.cursor_row}, 32'd1);
    send(8'h71);
    check("row1_addr", {20'd0, bus.mem_addr}, 32'd80);

    // Bottom row, then LF wraps to the top without writing
    send_n(8'h0A, 28);
    check("lf_row29", {27'd0, bus.cursor_row}, 32'd29);
    send_n(8'h63, 5);
    check("r29_addr", {20'd0, bus.mem_addr},   32'd2324);
    check("r29_col",  {25'd0, bus.cursor_col}, 32'd5);
    send(8'h0A);
    check("lfw_we",  {31'd0, bus.mem_we},     32'd0);
    check("lfw_col", {25'd0, bus.cursor_col}, 32'd0);
    check("lfw_row", {27'd0, bus.cursor_row}, 32'd0);

    // Backspace at row 2 col 3, then at col 0
    send_n(8'h0A, 2);
    send_n(8'h64, 3);
    send(8'h08);
    check("bs_we",   {31'd0, bus.mem_we},     32'd1);
    check("bs_addr", {20'd0, bus.mem_addr},   32'd162);
    check("bs_data", {24'd0, bus.mem_data},   32'h20);
    check("bs_col",  {25'd0, bus.cursor_col}, 32'd2);
    send(8'h0D);
    check("cr_col", {25'd0, bus.cursor_col}, 32'd0);
    check("cr_row", {27'd0, bus.cursor_row}, 32'd2);
    send(8'h08);
    check("bs0_we",  {31'd0, bus.mem_we},     32'd0);
    check("bs0_col", {25'd0, bus.cursor_col}, 32'd0);
    check("bs0_row", {27'd0, bus.cursor_row}, 32'd2);

    // Form feed, then reset in the middle of the sweep
    send(8'h0C);
    check("ff_busy",  {31'd0, bus.busy},       32'd1);
    check("ff_ready", {31'd0, bus.in_ready},   32'd0);
    check("ff_row",   {27'd0, bus.cursor_row}, 32'd0);
    n = 0;
    @(negedge clk);
    while (!(bus.mem_we && bus.mem_addr == 12'd1000) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ff_reach1000", {20'd0, bus.mem_addr}, 32'd1000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_we",   {31'd0, bus.mem_we},   32'd0);
    check("mid_rst_addr", {20'd0, bus.mem_addr}, 32'd0);
    check("mid_rst_busy", {31'd0, bus.busy},     32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_sweep("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
